dsp_mac_pipe: RTL and testbench

DSP_MAC_PIPE -- requirements
Module: dsp_mac_pipe

---
 rtl/dsp_mac_pipe.sv | 148 ++++++++++++++
 tb/tb_dsp_mac_pipe.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_pipe.sv
// Three-stage DSP multiply-accumulate pipeline.
// Stage 1 registers the operands. Stage 2 registers the pre-add and
// multiply result. Stage 3 performs the post-add/subtract. With ACC=1 the
// post-adder adds onto P, so back-to-back accumulation needs no stall.
// RST is synchronous and clears every stage. CE freezes the whole pipeline.
module dsp_mac_pipe #(
    parameter int AW  = 18,
    parameter int BW  = 18,
    parameter int DW  = 18,
    parameter int PW  = 48,
    parameter int SAT = 0
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          CE,
    input  logic          in_valid,
    input  logic [AW-1:0] A,
    input  logic [BW-1:0] B,
    input  logic [DW-1:0] D,
    input  logic [PW-1:0] C,
    input  logic          CARRYIN,
    input  logic [3:0]    OPMODE,
    output logic [PW-1:0] P,
    output logic          out_valid,
    output logic          CARRYOUT,
    output logic          OVF
);

    localparam int MW = AW + BW;

    // Stage 1 registers
    logic [AW-1:0] a_s1;
    logic [BW-1:0] b_s1;
    logic [DW-1:0] d_s1;
    logic [PW-1:0] c_s1;
    logic          cin_s1;
    logic [3:0]    op_s1;
    logic          valid_s1;

    // Stage 2 registers
    logic [MW-1:0] m_s2;
    logic [PW-1:0] c_s2;
    logic          cin_s2;
    logic          sub_s2;
    logic          acc_s2;
    logic          valid_s2;

    // Combinational pre-adder, multiplier and post-adder
    logic [BW-1:0] d_ext;
    logic [BW-1:0] pre_sum;
    logic [MW-1:0] m_next;
    logic [PW-1:0] z_sel;
    logic [PW:0]   z_ext;
    logic [PW:0]   m_ext;
    logic [PW:0]   post_sum;
    logic          post_flag;
    logic [PW-1:0] post_result;

    // Operand capture. The data registers are cleared on reset along with
    // the valid bits, so that P and the flags start at a known zero.
    always_ff @(posedge clk) begin
        // NOTE: every sequential assignment uses <= so that all stages
        // sample the values from before the edge, not their neighbours' new values.
        if (RST) begin
            a_s1     <= '0;
            b_s1     <= '0;
            d_s1     <= '0;
            c_s1     <= '0;
            cin_s1   <= 1'b0;
            op_s1    <= '0;
            valid_s1 <= 1'b0;
        end else if (CE) begin
            a_s1     <= A;
            b_s1     <= B;
            d_s1     <= D;
            c_s1     <= C;
            cin_s1   <= CARRYIN;
            op_s1    <= OPMODE;
            valid_s1 <= in_valid;
        end
    end

    // Pre-adder: D is zero-extended to BW bits, and the result wraps mod 2^BW.
    always_comb begin
        d_ext = BW'(d_s1);
        if (!op_s1[0]) begin
            pre_sum = b_s1;
        end else if (op_s1[1]) begin
            pre_sum = d_ext - b_s1;
        end else begin
            pre_sum = d_ext + b_s1;
        end
        m_next = MW'(pre_sum) * MW'(a_s1);
    end

    // Multiply result and the post-adder controls move down together.
    always_ff @(posedge clk) begin
        if (RST) begin
            m_s2     <= '0;
            c_s2     <= '0;
            cin_s2   <= 1'b0;
            sub_s2   <= 1'b0;
            acc_s2   <= 1'b0;
            valid_s2 <= 1'b0;
        end else if (CE) begin
            m_s2     <= m_next;
            c_s2     <= c_s1;
            cin_s2   <= cin_s1;
            sub_s2   <= op_s1[2];
            acc_s2   <= op_s1[3];
            valid_s2 <= valid_s1;
        end
    end

    // Post-adder, computed in PW+1 bits. On add, bit PW is the carry. On
    // subtract, the difference is less than 2^PW in magnitude, so bit PW is
    // the borrow flag.
    always_comb begin
        z_sel     = acc_s2 ? P : c_s2;
        z_ext     = {1'b0, z_sel};
        m_ext     = (PW + 1)'(m_s2) + (PW + 1)'(cin_s2);
        post_sum  = sub_s2 ? (z_ext - m_ext) : (z_ext + m_ext);
        post_flag = post_sum[PW];
        if ((SAT != 0) && post_flag) begin
            post_result = sub_s2 ? '0 : '1;
        end else begin
            post_result = post_sum[PW-1:0];
        end
    end

    // Result stage. Bubbles advance out_valid but leave P and the flags unchanged.
    always_ff @(posedge clk) begin
        if (RST) begin
            P         <= '0;
            CARRYOUT  <= 1'b0;
            OVF       <= 1'b0;
            out_valid <= 1'b0;
        end else if (CE) begin
            out_valid <= valid_s2;
            if (valid_s2) begin
                P        <= post_result;
                CARRYOUT <= post_flag;
                OVF      <= post_flag;
            end
        end
    end

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Bench for dsp_mac_pipe. Two instances, one wrapping and one saturating,
// are driven with the same inputs. Directed cases pin known answers. A
// random phase is then compared every cycle against a transaction-level
// model that evaluates each sample arithmetically as it leaves the pipe.
module tb_dsp_mac_pipe;

    localparam longint unsigned MASK_B = (64'd1 << 18) - 1;
    localparam longint unsigned MASK_P = (64'd1 << 48) - 1;

    logic        clk = 1'b0;
    logic        RST;
    logic        CE;
    logic        in_valid;
    logic [17:0] A;
    logic [17:0] B;
    logic [17:0] D;
    logic [47:0] C;
    logic        CARRYIN;
    logic [3:0]  OPMODE;

    logic [47:0] p_w, p_s;
    logic        ov_w, ov_s, co_w, co_s, ovf_w, ovf_s;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    dsp_mac_pipe #(.AW(18), .BW(18), .DW(18), .PW(48), .SAT(0)) u_wrap (
        .clk(clk), .RST(RST), .CE(CE), .in_valid(in_valid),
        .A(A), .B(B), .D(D), .C(C), .CARRYIN(CARRYIN), .OPMODE(OPMODE),
        .P(p_w), .out_valid(ov_w), .CARRYOUT(co_w), .OVF(ovf_w)
    );

    dsp_mac_pipe #(.AW(18), .BW(18), .DW(18), .PW(48), .SAT(1)) u_sat (
        .clk(clk), .RST(RST), .CE(CE), .in_valid(in_valid),
        .A(A), .B(B), .D(D), .C(C), .CARRYIN(CARRYIN), .OPMODE(OPMODE),
        .P(p_s), .out_valid(ov_s), .CARRYOUT(co_s), .OVF(ovf_s)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit              v;
        longint unsigned a, b, d, c;
        bit              cin;
        bit [3:0]        op;
    } samp_t;

    samp_t           flight [2];   // [0] newest accepted, [1] next to complete
    longint unsigned mp   [2];     // [0] wrapping, [1] saturating
    bit              mco  [2];
    bit              movf [2];
    bit              mov;

    task automatic complete(input samp_t s);
        longint unsigned pre, m, z, t, r;
        bit fl;
        if (s.op[0]) pre = (s.op[1] ? s.d - s.b : s.d + s.b) & MASK_B;
        else         pre = s.b;
        m = pre * s.a;
        for (int k = 0; k < 2; k++) begin
            z = s.op[3] ? mp[k] : s.c;
            if (!s.op[2]) begin
                t  = z + m + 64'(s.cin);
                fl = (t > MASK_P);
                r  = t & MASK_P;
                if (k == 1 && fl) r = MASK_P;
            end else begin
                t  = m + 64'(s.cin);
                fl = (t > z);
                r  = (z - t) & MASK_P;
                if (k == 1 && fl) r = 0;
            end
            mp[k]   = r;
            mco[k]  = fl;
            movf[k] = fl;
        end
    endtask

    always @(posedge clk) begin
        if (RST) begin
            flight[0].v = 1'b0;
            flight[1].v = 1'b0;
            mov = 1'b0;
            for (int k = 0; k < 2; k++) begin
                mp[k] = 0; mco[k] = 1'b0; movf[k] = 1'b0;
            end
        end else if (CE) begin
            mov = flight[1].v;
            if (flight[1].v) complete(flight[1]);
            flight[1] = flight[0];
            flight[0] = '{in_valid, 64'(A), 64'(B), 64'(D), 64'(C), CARRYIN, OPMODE};
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl_valid_w", 64'(ov_w),  64'(mov));
            check("mdl_p_w",     64'(p_w),   mp[0]);
            check("mdl_co_w",    64'(co_w),  64'(mco[0]));
            check("mdl_ovf_w",   64'(ovf_w), 64'(movf[0]));
            check("mdl_valid_s", 64'(ov_s),  64'(mov));
            check("mdl_p_s",     64'(p_s),   mp[1]);
            check("mdl_co_s",    64'(co_s),  64'(mco[1]));
            check("mdl_ovf_s",   64'(ovf_s), 64'(movf[1]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit iv, input longint unsigned a, b, d, c,
                         input bit cin, input bit [3:0] op);
        in_valid = iv;
        A        = a[17:0];
        B        = b[17:0];
        D        = d[17:0];
        C        = c[47:0];
        CARRYIN  = cin;
        OPMODE   = op;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    initial begin
        // Reset with live, nonzero operands.
        RST = 1'b1;
        CE  = 1'b1;
        drive(1, 7, 9, 11, 1234, 1, 4'b1001);
        cyc(2);
        check("rst_p",     64'(p_w),   0);
        check("rst_valid", 64'(ov_w),  0);
        check("rst_co",    64'(co_w),  0);
        check("rst_ovf",   64'(ovf_w), 0);
        RST = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 4'b0000);
        chk_en = 1'b1;
        cyc(3);

        // Pre-add multiply: (3+5)*1 + 100.
        drive(1, 1, 5, 3, 100, 0, 4'b0001);
        cyc(1); idle();
        check("pre_lat1", 64'(ov_w), 0);
        cyc(1);
        check("pre_lat2", 64'(ov_w), 0);
        cyc(1);
        check("pre_valid", 64'(ov_w), 1);
        check("pre_p",     64'(p_w),  108);
        cyc(1);
        check("pre_pulse", 64'(ov_w), 0);
        cyc(2);

        // Accumulate 3*4 four times.
        drive(1, 3, 4, 0, 0, 0, 4'b0000);
        cyc(1); drive(1, 3, 4, 0, 0, 0, 4'b1000);
        cyc(2);
        check("acc_p1", 64'(p_w), 12);
        cyc(1); idle();
        check("acc_p2", 64'(p_w), 24);
        cyc(1);
        check("acc_p3", 64'(p_w), 36);
        cyc(1);
        check("acc_p4", 64'(p_w), 48);
        cyc(2);

        // Post-subtract, then a borrow.
        drive(1, 8, 2, 0, 50, 1, 4'b0100);
        cyc(1); drive(1, 8, 2, 0, 10, 1, 4'b0100);
        cyc(1); idle();
        cyc(1);
        check("sub_p",    64'(p_w),  33);
        check("sub_co",   64'(co_w), 0);
        cyc(1);
        check("brw_p",    64'(p_w),   MASK_P - 6);
        check("brw_co",   64'(co_w),  1);
        check("brw_ovf",  64'(ovf_w), 1);
        check("brw_psat", 64'(p_s),   0);
        cyc(2);

        // Add overflow.
        drive(1, 1, 1, 0, MASK_P, 0, 4'b0000);
        cyc(1); idle();
        cyc(2);
        check("ovf_p",     64'(p_w),   0);
        check("ovf_co",    64'(co_w),  1);
        check("ovf_ovf",   64'(ovf_w), 1);
        check("ovf_psat",  64'(p_s),   MASK_P);
        check("ovf_osat",  64'(ovf_s), 1);
        cyc(2);

        // Stall two cycles, one edge after the sample.
        drive(1, 5, 6, 0, 50, 0, 4'b0000);
        cyc(1); idle(); CE = 1'b0;
        cyc(2); CE = 1'b1;
        check("stall_frozen", 64'(ov_w), 0);
        cyc(1);
        check("stall_early", 64'(ov_w), 0);
        cyc(1);
        check("stall_valid", 64'(ov_w), 1);
        check("stall_p",     64'(p_w),  80);
        cyc(2);

        // Reset with samples in flight, then accumulate from zero.
        drive(1, 100, 100, 0, 777, 0, 4'b1000);
        cyc(2);
        RST = 1'b1;
        cyc(1);
        RST = 1'b0;
        check("mid_rst_p", 64'(p_w), 0);
        drive(1, 2, 3, 0, 999, 0, 4'b1000);
        cyc(1); idle();
        check("mid_rst_drop", 64'(ov_w), 0);
        cyc(2);
        check("mid_rst_valid", 64'(ov_w), 1);
        check("mid_rst_acc",   64'(p_w),  6);
        cyc(2);

        // Randomized phase.
        for (int i = 0; i < 3000; i++) begin
            longint unsigned ra, rb, rd, rc;
            ra = ($urandom % 4 == 0) ? MASK_B : 64'($urandom) & MASK_B;
            rb = ($urandom % 4 == 0) ? MASK_B : 64'($urandom) & MASK_B;
            rd = 64'($urandom) & MASK_B;
            case ($urandom % 4)
                0:       rc = MASK_P - 64'($urandom % 64);
                1:       rc = 64'($urandom % 256);
                default: rc = {32'($urandom), 32'($urandom)} & MASK_P;
            endcase
            drive(($urandom % 4) != 0, ra, rb, rd, rc, 1'($urandom), 4'($urandom));
            CE  = ($urandom % 8) != 0;
            RST = ($urandom % 97) == 0;
            cyc(1);
        end
        RST = 1'b0;
        CE  = 1'b1;
        idle();
        cyc(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
